song_sequencer: RTL and testbench

- Upstream control stage of the Happy Birthday player.
- Steps through a fixed 25-entry melody table of (note code, duration) pairs.
- Drives one-hot enables into the per-pitch note clock dividers, and inserts a silent gap after every note so repeated pitches re-articulate.
- Each downstream divider clears its counter whenever its enable is low.

---
 rtl/song_sequencer_pkg.sv | 37 +++
 rtl/song_rom.sv | 40 ++++
 rtl/song_sequencer.sv | 167 ++++++++++++++++
 tb/tb_song_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_sequencer_pkg.sv
// Shared constants for the Happy Birthday song sequencer: note codes, durations,
// FSM state encoding and the melody table entry layout.
package song_sequencer_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned DUR_W  = 7;

    localparam logic [CODE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [CODE_W-1:0] NOTE_G4   = 4'd1;
    localparam logic [CODE_W-1:0] NOTE_A4   = 4'd2;
    localparam logic [CODE_W-1:0] NOTE_B4   = 4'd3;
    localparam logic [CODE_W-1:0] NOTE_C5   = 4'd4;
    localparam logic [CODE_W-1:0] NOTE_D5   = 4'd5;
    localparam logic [CODE_W-1:0] NOTE_E5   = 4'd6;
    localparam logic [CODE_W-1:0] NOTE_F5   = 4'd7;
    localparam logic [CODE_W-1:0] NOTE_G5   = 4'd8;

    localparam logic [DUR_W-1:0] D_Q  = 7'd40;
    localparam logic [DUR_W-1:0] D_DE = 7'd30;
    localparam logic [DUR_W-1:0] D_S  = 7'd10;
    localparam logic [DUR_W-1:0] D_H  = 7'd80;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NOTE = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [DUR_W-1:0]  dur;
    } entry_t;

    // A zero duration still plays for one tick.
    function automatic logic [DUR_W-1:0] dur_ticks(input logic [DUR_W-1:0] dur);
        return (dur == '0) ? DUR_W'(1) : dur;
    endfunction

endpackage

// File: rtl/song_rom.sv
// Melody table: combinational lookup of table index to {note code, duration}.
module song_rom
    import song_sequencer_pkg::*;
(
    input  logic [4:0] step_idx_i,
    output entry_t     entry_o
);

    always_comb begin
        case (step_idx_i)
            5'd0:    entry_o = {NOTE_G4, D_DE};
            5'd1:    entry_o = {NOTE_G4, D_S};
            5'd2:    entry_o = {NOTE_A4, D_Q};
            5'd3:    entry_o = {NOTE_G4, D_Q};
            5'd4:    entry_o = {NOTE_C5, D_Q};
            5'd5:    entry_o = {NOTE_B4, D_H};
            5'd6:    entry_o = {NOTE_G4, D_DE};
            5'd7:    entry_o = {NOTE_G4, D_S};
            5'd8:    entry_o = {NOTE_A4, D_Q};
            5'd9:    entry_o = {NOTE_G4, D_Q};
            5'd10:   entry_o = {NOTE_D5, D_Q};
            5'd11:   entry_o = {NOTE_C5, D_H};
            5'd12:   entry_o = {NOTE_G4, D_DE};
            5'd13:   entry_o = {NOTE_G4, D_S};
            5'd14:   entry_o = {NOTE_G5, D_Q};
            5'd15:   entry_o = {NOTE_E5, D_Q};
            5'd16:   entry_o = {NOTE_C5, D_Q};
            5'd17:   entry_o = {NOTE_B4, D_Q};
            5'd18:   entry_o = {NOTE_A4, D_H};
            5'd19:   entry_o = {NOTE_F5, D_DE};
            5'd20:   entry_o = {NOTE_F5, D_S};
            5'd21:   entry_o = {NOTE_E5, D_Q};
            5'd22:   entry_o = {NOTE_C5, D_Q};
            5'd23:   entry_o = {NOTE_D5, D_Q};
            5'd24:   entry_o = {NOTE_C5, D_H};
            default: entry_o = {NOTE_REST, 7'd1};
        endcase
    end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer FSM: walks the melody table, drives one-hot pitch enables and
// inserts a silent gap after each note so repeated pitches re-articulate.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 1_000_000,
    parameter int unsigned GAP_TICKS   = 5,
    parameter int unsigned SONG_LEN    = 25,
    parameter int unsigned NUM_NOTES   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 loop_i,
    output logic [NUM_NOTES-1:0] note_en_o,
    output logic [CODE_W-1:0]    note_code_o,
    output logic [4:0]           step_idx_o,
    output logic                 busy_o,
    output logic                 song_done_o
);

    localparam int unsigned      PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_CYCLES - 1);
    localparam logic [DUR_W-1:0] GAP_MAX   = DUR_W'(GAP_TICKS - 1);
    localparam logic [4:0]       LAST_IDX  = 5'(SONG_LEN - 1);

    logic [1:0]           state_q, state_d;
    logic [4:0]           step_q, step_d;
    logic [DUR_W-1:0]     tick_q, tick_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [DUR_W-1:0]     dur_q, dur_d;
    logic [NUM_NOTES-1:0] note_en_q, note_en_d;
    logic [CODE_W-1:0]    code_q, code_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    entry_t               rom_entry;
    logic [4:0]           rom_idx;
    logic [NUM_NOTES-1:0] rom_en;
    logic                 tick, last, phase_end;
    logic                 load, clear, advance;

    song_rom u_rom (
        .step_idx_i (rom_idx),
        .entry_o    (rom_entry)
    );

    always_comb begin
        rom_en = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            rom_en[i] = (rom_entry.code == CODE_W'(i + 1));
        end
    end

    // The ROM is always addressed with the step that would be loaded next.
    always_comb begin
        tick      = (presc_q == PRESC_MAX);
        last      = (step_q == LAST_IDX);
        rom_idx   = (state_q == ST_IDLE || last) ? 5'd0 : step_q + 5'd1;
        phase_end = tick && ((state_q == ST_NOTE) ? (tick_q == dur_q - 1'b1)
                                                  : (tick_q == GAP_MAX));
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        tick_d    = tick_q;
        presc_d   = presc_q;
        dur_d     = dur_q;
        note_en_d = note_en_q;
        code_d    = code_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load      = 1'b0;
        clear     = 1'b0;
        advance   = 1'b0;

        if (busy_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            tick_d  = tick ? tick_q + 1'b1 : tick_q;
        end

        case (state_q)
            ST_IDLE: load = start_i;
            ST_NOTE: begin
                if (phase_end) begin
                    if (GAP_TICKS == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        note_en_d = '0;
                        tick_d    = '0;
                        presc_d   = '0;
                    end
                end
            end
            ST_GAP:  advance = phase_end;
            default: clear = 1'b1;
        endcase

        if (advance) begin
            done_d = last;
            if (last && !loop_i) clear = 1'b1;
            else                 load  = 1'b1;
        end

        if (stop_i) begin
            clear  = 1'b1;
            load   = 1'b0;
            done_d = 1'b0;
        end

        if (clear) begin
            state_d   = ST_IDLE;
            step_d    = '0;
            tick_d    = '0;
            presc_d   = '0;
            dur_d     = '0;
            note_en_d = '0;
            code_d    = '0;
            busy_d    = 1'b0;
        end

        if (load) begin
            state_d   = ST_NOTE;
            step_d    = rom_idx;
            tick_d    = '0;
            presc_d   = '0;
            dur_d     = dur_ticks(rom_entry.dur);
            note_en_d = rom_en;
            code_d    = rom_entry.code;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            tick_q    <= '0;
            presc_q   <= '0;
            dur_q     <= '0;
            note_en_q <= '0;
            code_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            tick_q    <= tick_d;
            presc_q   <= presc_d;
            dur_q     <= dur_d;
            note_en_q <= note_en_d;
            code_q    <= code_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign note_en_o   = note_en_q;
    assign note_code_o = code_q;
    assign step_idx_o  = step_q;
    assign busy_o      = busy_q;
    assign song_done_o = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench: a melody-level model predicts output segments and song_done
// cycles; a negedge monitor measures the DUT's segments and compares.
module tb_song_sequencer;

    localparam int TICK  = 4;
    localparam int GAP   = 1;
    localparam int NSTEP = 25;

    localparam int MCODE [NSTEP] = '{1, 1, 2, 1, 4, 3,
                                     1, 1, 2, 1, 5, 4,
                                     1, 1, 8, 6, 4, 3, 2,
                                     7, 7, 6, 4, 5, 4};
    localparam int MDUR [NSTEP]  = '{30, 10, 40, 40, 40, 80,
                                     30, 10, 40, 40, 40, 80,
                                     30, 10, 40, 40, 40, 40, 80,
                                     30, 10, 40, 40, 40, 80};

    typedef struct {
        logic [17:0] tup;
        int          len;
    } seg_t;

    typedef struct {
        int   cyc;
        logic busy;
    } done_t;

    logic       clk, rst, start, stop, loop_s;
    logic [7:0] note_en;
    logic [3:0] note_code;
    logic [4:0] step_idx;
    logic       busy, song_done;

    seg_t        segq[$];
    done_t       doneq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          run = 0;
    logic [17:0] prev;
    logic [17:0] mon_cur;

    song_sequencer #(
        .TICK_CYCLES (TICK),
        .GAP_TICKS   (GAP),
        .SONG_LEN    (NSTEP),
        .NUM_NOTES   (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .stop_i      (stop),
        .loop_i      (loop_s),
        .note_en_o   (note_en),
        .note_code_o (note_code),
        .step_idx_o  (step_idx),
        .busy_o      (busy),
        .song_done_o (song_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] onehot(input int c);
        return (c == 0) ? 8'd0 : 8'(1 << (c - 1));
    endfunction

    function automatic int note_len(input int i);
        return ((MDUR[i] == 0) ? 1 : MDUR[i]) * TICK;
    endfunction

    function automatic int seg_start(input int step);
        int s = 0;
        for (int i = 0; i < step; i++) s += note_len(i) + GAP * TICK;
        return s;
    endfunction

    function automatic int pass_len();
        return seg_start(NSTEP);
    endfunction

    function automatic void push_seg(input int t, input int abort, input logic [17:0] tup,
                                     input int len);
        seg_t s;
        int   l = len;
        if (abort > 0) begin
            if (t >= abort) return;
            if (t + l > abort) l = abort - t;
        end
        s.tup = tup;
        s.len = l;
        segq.push_back(s);
    endfunction

    // Expected output segments for a playback starting after sample n0, cut after
    // 'abort' samples when abort > 0.
    function automatic void build(input int n0, input int passes, input int abort);
        int    t = 0;
        int    d;
        done_t e;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < NSTEP; i++) begin
                push_seg(t, abort, {1'b1, 5'(i), onehot(MCODE[i]), 4'(MCODE[i])}, note_len(i));
                t += note_len(i);
                if (GAP > 0) begin
                    push_seg(t, abort, {1'b1, 5'(i), 8'd0, 4'(MCODE[i])}, GAP * TICK);
                    t += GAP * TICK;
                end
            end
            d = t + 1;
            if (abort == 0 || d <= abort) begin
                e.cyc  = n0 + d;
                e.busy = (p < passes - 1);
                doneq.push_back(e);
            end
        end
    endfunction

    function automatic void fail_seg(input logic [17:0] got, input int glen,
                                     input logic [17:0] exp, input int elen);
        $display("FAIL segment@%0d: got busy=%0b step=%0d en=%b code=%0d len=%0d, expected busy=%0b step=%0d en=%b code=%0d len=%0d",
                 cyc, got[17], got[16:12], got[11:4], got[3:0], glen,
                 exp[17], exp[16:12], exp[11:4], exp[3:0], elen);
    endfunction

    // Monitor: measures constant-output runs and checks them against the scoreboard.
    always @(negedge clk) begin
        seg_t  e;
        done_t d;
        mon_cur = {busy, step_idx, note_en, note_code};
        cyc++;
        if (cyc == 1) begin
            run = 1;
        end else if (mon_cur != prev) begin
            if (prev[17]) begin
                n_chk++;
                if (segq.size() == 0) begin
                    n_fail++;
                    fail_seg(prev, run, 18'd0, 0);
                end else begin
                    e = segq.pop_front();
                    if (e.tup != prev || e.len != run) begin
                        n_fail++;
                        fail_seg(prev, run, e.tup, e.len);
                    end
                end
            end
            if (!mon_cur[17]) begin
                n_chk++;
                if (mon_cur != '0) begin
                    n_fail++;
                    $display("FAIL idle_outputs@%0d: got %h, expected 0", cyc, mon_cur);
                end
            end
            run = 1;
        end else begin
            run++;
        end
        if (song_done) begin
            n_chk++;
            if (doneq.size() == 0) begin
                n_fail++;
                $display("FAIL song_done@%0d: got pulse, expected none", cyc);
            end else begin
                d = doneq.pop_front();
                if (d.cyc != cyc || d.busy != busy) begin
                    n_fail++;
                    $display("FAIL song_done: got cycle %0d busy=%0b, expected cycle %0d busy=%0b",
                             cyc, busy, d.cyc, d.busy);
                end
            end
        end
        prev = mon_cur;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {14'd0, busy, song_done, step_idx, note_en, note_code}, 32'd0);
    endtask

    task automatic run_play(input int passes, input int abort, input bit use_rst,
                            input bit poke_start);
        int n0, total, waited;
        @(negedge clk);
        #1;
        n0 = cyc;
        build(n0, passes, abort);
        loop_s = (passes > 1);
        start  = 1'b1;
        @(negedge clk);
        #1;
        start  = 1'b0;
        waited = 1;
        total  = (abort > 0) ? abort : passes * pass_len();
        while (waited < total) begin
            @(negedge clk);
            #1;
            waited++;
            start = (poke_start && waited == 200);
            if (passes > 1 && waited == (passes - 1) * pass_len() + 10) loop_s = 1'b0;
        end
        start = 1'b0;
        if (abort > 0) begin
            if (use_rst) begin
                rst = 1'b1;
                #1;
                check_all_zero("async_reset_clears");
                repeat (2) @(negedge clk);
                #1;
                rst = 1'b0;
                repeat (20) @(negedge clk);
                #1;
                check("idle_after_reset", {31'd0, busy}, 32'd0);
            end else begin
                stop = 1'b1;
                @(negedge clk);
                #1;
                stop = 1'b0;
            end
        end
        repeat (5) @(negedge clk);
        #1;
        loop_s = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        loop_s = 1'b0;
        #2;
        check_all_zero("reset_state");
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;

        // First notes, then asynchronous reset in the middle of step 3.
        run_play(1, seg_start(3) + int'($urandom_range(1, note_len(3) - 1)), 1'b1, 1'b0);
        // Full pass with a start pulse while busy.
        run_play(1, 0, 1'b0, 1'b1);
        // Two looped passes.
        run_play(2, 0, 1'b0, 1'b0);
        // Stop in the middle of step 10.
        run_play(1, seg_start(10) + int'($urandom_range(1, note_len(10) - 1)), 1'b0, 1'b0);

        // start and stop together in IDLE.
        @(negedge clk);
        #1;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("start_stop_idle");

        // Random abort points and abort kinds.
        for (int k = 0; k < 2; k++) begin
            run_play(1, int'($urandom_range(1, pass_len())), 1'($urandom_range(0, 1)), 1'b0);
        end

        check("segments_drained", 32'(segq.size()), 32'd0);
        check("dones_drained", 32'(doneq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
